// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding I-cache request feeding a circular buffer of fetched entries.
// Optional macro IFETCH_JAL_PREDICT_EN enables static JAL target prediction for the next fetch PC.
module ifetch_queue #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        IF_rn,
  output logic [31:0] IF_addr,
  input  logic        IF_ready,
  input  logic [31:0] IF_inst,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  input  logic        inst_deq,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             state_reg;
  logic [31:0]        pc_reg;
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               if_rn_reg;
  logic [31:0]        if_addr_reg;

  logic [31:0] inst_mem [QUEUE_DEPTH];
  logic [31:0] pc_mem   [QUEUE_DEPTH];
  logic [31:0] pred_mem [QUEUE_DEPTH];

  logic [31:0] next_pc;
  logic        push_en;
  logic        pop_en;
  logic        issue_en;

`ifdef IFETCH_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{11{IF_inst[31]}}, IF_inst[31], IF_inst[19:12], IF_inst[20], IF_inst[30:21], 1'b0};
`endif

  always_comb begin
    next_pc = pc_reg + 32'd4;
`ifdef IFETCH_JAL_PREDICT_EN
    if (IF_inst[6:0] == 7'b1101111) begin
      next_pc = pc_reg + jal_imm;
    end
`endif
  end

  // A push only happens from WAIT; pc_reg equals the outstanding address there.
  assign push_en  = rdy && (state_reg == WAIT) && IF_ready && !flush;
  assign pop_en   = rdy && inst_deq && (count_reg != '0) && !flush;
  assign issue_en = rdy && (state_reg == IDLE) && !flush && (count_reg < CNT_W'(QUEUE_DEPTH));

  always_ff @(posedge clk) begin
    if (push_en) begin
      inst_mem[tail_reg] <= IF_inst;
      pc_mem[tail_reg]   <= pc_reg;
      pred_mem[tail_reg] <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      if_rn_reg   <= 1'b0;
      if_addr_reg <= RESET_PC;
    end else if (rdy) begin
      if (flush) begin
        count_reg <= '0;
        head_reg  <= '0;
        tail_reg  <= '0;
        pc_reg    <= flush_pc;
      end else begin
        if (push_en) begin
          tail_reg <= tail_reg + PTR_W'(1);
          pc_reg   <= next_pc;
        end
        if (pop_en) begin
          head_reg <= head_reg + PTR_W'(1);
        end
        case ({push_en, pop_en})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end

      case (state_reg)
        IDLE: begin
          if (issue_en) begin
            state_reg   <= WAIT;
            if_rn_reg   <= 1'b1;
            if_addr_reg <= pc_reg;
          end
        end
        WAIT: begin
          // A response coinciding with a flush is simply dropped.
          if (IF_ready) begin
            state_reg <= IDLE;
            if_rn_reg <= 1'b0;
          end else if (flush) begin
            state_reg <= DROP;
          end
        end
        DROP: begin
          if (IF_ready) begin
            state_reg <= IDLE;
            if_rn_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          if_rn_reg <= 1'b0;
        end
      endcase
    end
  end

  assign IF_rn        = if_rn_reg;
  assign IF_addr      = if_addr_reg;
  assign inst_valid   = (count_reg != '0);
  assign inst_out     = inst_valid ? inst_mem[head_reg] : 32'h0;
  assign inst_pc      = inst_valid ? pc_mem[head_reg]   : 32'h0;
  assign inst_pred_pc = inst_valid ? pred_mem[head_reg] : 32'h0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: fill, drain, push/pop overlap, rdy stall, flush, prediction, wrap, reset.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        IF_rn;
  logic [31:0] IF_addr;
  logic        IF_ready = 1'b0;
  logic [31:0] IF_inst = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pred_pc;
  logic        inst_deq = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;

  int checks = 0;
  int errors = 0;

`ifdef IFETCH_JAL_PREDICT_EN
  localparam logic [31:0] JAL_PRED = 32'h20;
`else
  localparam logic [31:0] JAL_PRED = 32'h14;
`endif

  ifetch_queue #(.QUEUE_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IF_rn(IF_rn), .IF_addr(IF_addr), .IF_ready(IF_ready), .IF_inst(IF_inst),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_pred_pc(inst_pred_pc),
    .inst_deq(inst_deq), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-12s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_rn();
    int n = 0;
    while (IF_rn !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_rn", {31'h0, IF_rn}, 32'h1);
  endtask

  task automatic respond(input logic [31:0] inst);
    IF_ready = 1'b1;
    IF_inst  = inst;
    @(negedge clk);
    IF_ready = 1'b0;
  endtask

  task automatic pop_one();
    inst_deq = 1'b1;
    @(negedge clk);
    inst_deq = 1'b0;
  endtask

  // Flush in WAIT together with a response: straight back to IDLE, response dropped.
  task automatic redirect(input logic [31:0] target);
    flush    = 1'b1;
    flush_pc = target;
    IF_ready = 1'b1;
    IF_inst  = 32'hEEEE_EEEE;
    @(negedge clk);
    flush    = 1'b0;
    IF_ready = 1'b0;
    check("redir_rn", {31'h0, IF_rn}, 32'h0);
    check("redir_vld", {31'h0, inst_valid}, 32'h0);
    wait_rn();
    check("redir_addr", IF_addr, target);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_rn", {31'h0, IF_rn}, 32'h0);
    check("rst_addr", IF_addr, 32'h0);
    check("rst_vld", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_pred", inst_pred_pc, 32'h0);
    rst = 1'b1;

    // Fill to 8 entries with sequential fetches
    for (int i = 0; i < 8; i++) begin
      wait_rn();
      check("fill_addr", IF_addr, 32'(i * 4));
      respond(32'hA000_0000 | 32'(i));
      check("fill_vld", {31'h0, inst_valid}, 32'h1);
    end
    check("head_inst", inst_out, 32'hA000_0000);
    check("head_pc", inst_pc, 32'h0);
    check("head_pred", inst_pred_pc, 32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_norn", {31'h0, IF_rn}, 32'h0);
    end

    // One pop from full -> exactly one request at 0x20
    pop_one();
    check("pop_pc", inst_pc, 32'h4);
    check("pop_inst", inst_out, 32'hA000_0001);
    check("pop_norn", {31'h0, IF_rn}, 32'h0);
    wait_rn();
    check("refill_addr", IF_addr, 32'h20);
    respond(32'hA000_0008);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("refull_norn", {31'h0, IF_rn}, 32'h0);
    end

    // Drain to 3 entries, then push and pop in the same cycle
    inst_deq = 1'b1;
    repeat (5) @(negedge clk);
    inst_deq = 1'b0;
    check("drain_pc", inst_pc, 32'h18);
    wait_rn();
    check("pp_addr", IF_addr, 32'h24);
    IF_ready = 1'b1;
    IF_inst  = 32'hB000_0024;
    inst_deq = 1'b1;
    @(negedge clk);
    IF_ready = 1'b0;
    inst_deq = 1'b0;
    check("pp_head", inst_pc, 32'h1c);
    pop_one();
    check("pp_pc1", inst_pc, 32'h20);
    pop_one();
    check("pp_pc2", inst_pc, 32'h24);
    check("pp_inst", inst_out, 32'hB000_0024);
    check("pp_pred", inst_pred_pc, 32'h28);
    pop_one();
    check("pp_empty", {31'h0, inst_valid}, 32'h0);

    // rdy low: responses and pops ignored
    wait_rn();
    check("stall_addr", IF_addr, 32'h28);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      IF_ready = ~IF_ready;
      IF_inst  = 32'hDEAD_0000 | 32'(i);
      inst_deq = 1'b1;
      @(negedge clk);
      check("stall_rn", {31'h0, IF_rn}, 32'h1);
      check("stall_addr", IF_addr, 32'h28);
      check("stall_vld", {31'h0, inst_valid}, 32'h0);
    end
    IF_ready = 1'b0;
    inst_deq = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    check("resume_rn", {31'h0, IF_rn}, 32'h1);
    check("resume_vld", {31'h0, inst_valid}, 32'h0);
    respond(32'hC000_0028);
    check("resume_vld2", {31'h0, inst_valid}, 32'h1);
    check("resume_pc", inst_pc, 32'h28);
    check("resume_inst", inst_out, 32'hC000_0028);

    // Flush while waiting -> DROP, late response discarded
    wait_rn();
    check("fl_addr0", IF_addr, 32'h2c);
    flush = 1'b1;
    flush_pc = 32'h1000;
    @(negedge clk);
    flush = 1'b0;
    check("drop_rn", {31'h0, IF_rn}, 32'h1);
    check("drop_addr", IF_addr, 32'h2c);
    check("drop_vld", {31'h0, inst_valid}, 32'h0);
    respond(32'hD000_002C);
    check("drop_rn0", {31'h0, IF_rn}, 32'h0);
    check("drop_vld2", {31'h0, inst_valid}, 32'h0);
    wait_rn();
    check("fl_addr", IF_addr, 32'h1000);
    check("fl_vld", {31'h0, inst_valid}, 32'h0);

    // JAL prediction at pc 0x10
    redirect(32'h10);
    respond(32'h0100_006F);
    check("jal_pc", inst_pc, 32'h10);
    check("jal_pred", inst_pred_pc, JAL_PRED);
    wait_rn();
    check("jal_next", IF_addr, JAL_PRED);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    respond(32'h0000_0013);
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_pred", inst_pred_pc, 32'h0);
    wait_rn();
    check("wrap_next", IF_addr, 32'h0);
    respond(32'h0000_0013);
    wait_rn();
    check("pre_rst", IF_addr, 32'h4);

    // Asynchronous reset in the middle of WAIT
    #2 rst = 1'b0;
    #1;
    check("arst_rn", {31'h0, IF_rn}, 32'h0);
    check("arst_addr", IF_addr, 32'h0);
    check("arst_vld", {31'h0, inst_valid}, 32'h0);
    check("arst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_rn();
    check("post_rst", IF_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
